seg_scan_mux: RTL
=================

# seg_scan_mux

Time-multiplexed driver for the board's seven-segment display bank. It sits directly downstream of the hex seven-segment decoders. It takes the five decoded 7-bit digit patterns (PC, INSTRH, INSTRL, ACH, ACL) and scans them onto one shared segment bus plus per-digit enable lines. A frame snapshot keeps a frame tear-free while the processor state changes.

## Interface
Parameters:
- NUM_DIGITS, 5: number of scanned digits.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be ≥ 2.
- GUARD_CYCLES, 16: blank cycles at the start of each slot; only used with SEG_SCAN_GUARD_EN; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit by 0; sets the blank pattern.
- AN_ACTIVE_LOW, 1: 1 means a digit is enabled by 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- seg_in  in  7*NUM_DIGITS  decoded patterns; digit i = seg_in[7*i+6:7*i]; integration maps ACL=0, ACH=1, INSTRL=2, INSTRH=3, PC=4.
- seg_out  out  7  shared segment bus; registered.
- an_out  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW; registered.
- frame_tick  out  1  one-cycle pulse per frame start; registered.

## Operation
- Blank pattern: SEG_OFF = all ones if SEG_ACTIVE_LOW, else all zeros. AN_OFF is defined the same way from AN_ACTIVE_LOW.
- State: slot counter div_cnt (0..REFRESH_DIV-1), digit index dig (0..NUM_DIGITS-1), phase {PH_GUARD, PH_SHOW}, and a snapshot register of 7*NUM_DIGITS bits.
- Reset: div_cnt=0, dig=0, snapshot=all SEG_OFF, seg_out=SEG_OFF, an_out=AN_OFF, frame_tick=0. Phase resets to PH_GUARD if the guard is compiled in, else PH_SHOW.
- div_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and dig advances. dig wraps from NUM_DIGITS-1 to 0.
- Frame start: a non-reset cycle with dig=0 and div_cnt=0. This occurs on the first cycle after reset release and after every dig wrap. On that edge:
  - snapshot <= seg_in.
  - frame_tick <= 1. It is 0 on all other edges.
- Output update each edge:
  - In a show cycle: an_out <= enable for dig; seg_out <= snapshot slice for dig. At frame start the digit-0 slice is taken directly from seg_in, so no stale value appears.
  - In a guard cycle: an_out <= AN_OFF; seg_out <= SEG_OFF.
- seg_in changes mid-frame have no effect on the display until the next frame start.
- Exactly one digit is enabled in any show cycle. No digit is enabled during reset or guard cycles.

## Timing
- Let edge 0 be the first rising edge with reset low.
- Without guard:
  - Digit 0 is visible for the REFRESH_DIV cycles following edges 0..REFRESH_DIV-1.
  - Digit k is first visible after edge k*REFRESH_DIV.
  - Output latency is 1 cycle after the state edge.
- With guard:
  - Each slot shows GUARD_CYCLES blank cycles, then REFRESH_DIV-GUARD_CYCLES show cycles.
  - Slot length is unchanged.
- frame_tick is high during the cycle following edge 0, then every NUM_DIGITS*REFRESH_DIV cycles.
- Reset asserted mid-frame: outputs blank on the next edge. After release, the scan restarts at digit 0 with a fresh snapshot; no partial slot resumes.

## Configuration
- SEG_SCAN_GUARD_EN defined: PH_GUARD is active and each slot begins with GUARD_CYCLES blank cycles. This suppresses ghosting on the digit switch.
- SEG_SCAN_GUARD_EN undefined: phase is always PH_SHOW, GUARD_CYCLES is ignored, and every slot cycle is a show cycle.

## Structure
- Package seg_scan_pkg holds:
  - SEG_W = 7.
  - The phase enum {PH_GUARD, PH_SHOW}.
  - Functions seg_off(active_low) and an_onehot(idx, active_low).
- Sub-module seg_scan_timer holds div_cnt, dig, phase and the frame_start strobe. seg_scan_mux holds the snapshot and output registers.

## Test plan
Bench parameters: REFRESH_DIV=4, NUM_DIGITS=5, active-low defaults. seg_in digits are 7'h01, 02, 04, 08, 10 for indices 0..4.
- Reset for 3 cycles -> an_out=5'b11111, seg_out=7'h7F, frame_tick=0 throughout.
- Release reset (guard off):
  - an_out = 11110 for 4 cycles, then 11101, 11011, 10111, 01111 for 4 cycles each.
  - seg_out matches each digit's pattern.
  - frame_tick pulses at cycle 1 and then every 20 cycles.
- Snapshot:
  - Change digit 2 to 7'h55 during the digit-1 slot -> digit 2 still shows 7'h04 this frame.
  - Shows 7'h55 after the next frame_tick.
- Guard on, GUARD_CYCLES=1 -> each slot is 1 cycle of an_out=11111/seg_out=7'h7F, then 3 active cycles. Frame period remains 20.
- Assert reset during the digit-3 slot -> next cycle an_out=11111. After release, digit 0 is shown with the current seg_in and frame_tick pulses.
- AN_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0 -> first slot an_out=5'b00001. During reset, seg_out=7'h00 and an_out=5'b00000.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan multiplexer.
// Optional feature macro: SEG_SCAN_GUARD_EN (blank guard cycles per slot).
package seg_scan_pkg;

    localparam int SEG_W  = 7;
    localparam int AN_MAX = 32;

    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    // Blank segment pattern for the given polarity.
    function automatic logic [SEG_W-1:0] seg_off(input logic active_low);
        return {SEG_W{active_low}};
    endfunction

    // One-hot digit enable (bit idx asserted), inverted for active-low anodes.
    function automatic logic [AN_MAX-1:0] an_onehot(input int unsigned idx, input logic active_low);
        logic [AN_MAX-1:0] oh;
        oh = AN_MAX'(1) << idx;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: div_cnt counts cycles within a digit slot, dig selects the
// digit, phase marks blank guard cycles at the start of each slot.
// Optional feature macro: SEG_SCAN_GUARD_EN.
//
//   phase    | meaning
//   ---------+------------------------------------------------
//   PH_GUARD | first GUARD_CYCLES of a slot, display blanked
//   PH_SHOW  | current digit driven onto the segment bus
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16,
    parameter int DIG_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    parameter int DIV_W        = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [DIG_W-1:0] dig,
    output phase_e           phase,
    output logic             frame_start
);

    if (REFRESH_DIV < 2 || GUARD_CYCLES >= REFRESH_DIV) begin : g_bad_params
        $error("seg_scan_timer: need REFRESH_DIV >= 2 and GUARD_CYCLES < REFRESH_DIV");
    end

`ifdef SEG_SCAN_GUARD_EN
    localparam phase_e PH_RESET = PH_GUARD;
`else
    localparam phase_e PH_RESET = PH_SHOW;
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    phase_e           phase_q, phase_d;

    // Next-state: advance slot counter, step digit on slot wrap, derive phase.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        dig_d     = dig_q;
        if (div_cnt_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt_d = '0;
            dig_d     = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
`ifdef SEG_SCAN_GUARD_EN
        phase_d = (div_cnt_d < DIV_W'(GUARD_CYCLES)) ? PH_GUARD : PH_SHOW;
`else
        phase_d = PH_SHOW;
`endif
    end

    // Timer state registers; reset restarts the scan at digit 0, slot start.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            dig_q     <= '0;
            phase_q   <= PH_RESET;
        end else begin
            div_cnt_q <= div_cnt_d;
            dig_q     <= dig_d;
            phase_q   <= phase_d;
        end
    end

    assign dig         = dig_q;
    assign phase       = phase_q;
    assign frame_start = (div_cnt_q == '0) && (dig_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: snapshots all digit patterns at
// frame start and scans them onto a shared segment bus with one-hot enables.
// Optional feature macro: SEG_SCAN_GUARD_EN (blank guard cycles per slot).
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 5,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_tick
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SEG_W-1:0]            SEG_OFF  = seg_off(SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0]       AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [SEG_W*NUM_DIGITS-1:0] SNAP_OFF = {NUM_DIGITS{SEG_OFF}};

    logic [DIG_W-1:0] dig;
    phase_e           phase;
    logic             frame_start;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYCLES(GUARD_CYCLES),
        .DIG_W       (DIG_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .dig        (dig),
        .phase      (phase),
        .frame_start(frame_start)
    );

    logic [SEG_W*NUM_DIGITS-1:0] snapshot_q, snapshot_d;
    logic [SEG_W-1:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        tick_q, tick_d;
    logic [AN_MAX-1:0]           an_full;

    // Capture a fresh frame at frame start and select the current digit;
    // the digit-0 slice comes straight from seg_in on that edge.
    always_comb begin
        snapshot_d = snapshot_q;
        tick_d     = 1'b0;
        seg_d      = SEG_OFF;
        an_d       = AN_OFF;
        an_full    = an_onehot(32'(dig), AN_ACTIVE_LOW != 0);
        if (frame_start) begin
            snapshot_d = seg_in;
            tick_d     = 1'b1;
        end
        if (phase == PH_SHOW) begin
            an_d  = an_full[NUM_DIGITS-1:0];
            seg_d = snapshot_d[32'(dig)*SEG_W +: SEG_W];
        end
    end

    // Snapshot and registered outputs; reset blanks the display at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot_q <= SNAP_OFF;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
            tick_q     <= 1'b0;
        end else begin
            snapshot_q <= snapshot_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_tick = tick_q;

endmodule
